ysyx_mem_arbiter: RTL and testbench

Two-master, one-slave memory arbiter that shares the core's single memory port between instruction fetch (IFU) and load/store (LSU). It sits between the fetch/execute units and the `pmem` access path. It accepts one request at a time, forwards it to memory, waits for the response and routes it back to the owner. The arbiter uses round-robin priority on ties, a response timeout and a sticky error flag.

---
 rtl/ysyx_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ysyx_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_mem_arbiter
//  Purpose  : Shares one memory port between instruction fetch (IFU) and
//             load/store (LSU). Only one transaction is outstanding at a time.
//             Ties are broken round-robin. A response timeout aborts a stuck
//             transaction. A sticky error flag records timeouts and responses
//             that arrive outside WAIT.
//  Ports    : clk, rst (async, active-low)
//             ifu_req_valid/ready, ifu_addr   -> ifu_rsp_valid, ifu_rsp_data
//             lsu_req_valid/ready, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask
//                                             -> lsu_rsp_valid, lsu_rsp_data
//             mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask
//             mem_rsp_valid, mem_rsp_data
//             err (sticky until reset)
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  // instruction fetch master (read only)
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_rsp_valid,
  output logic [DW-1:0]   ifu_rsp_data,
  // load/store master
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_rsp_valid,
  output logic [DW-1:0]   lsu_rsp_data,
  // memory slave port
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_data,
  // status
  output logic            err
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_req  = 2'd1;
  localparam logic [1:0] c_wait = 2'd2;

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  logic [1:0]      r_state;
  logic            r_owner_lsu;
  logic            r_last_lsu;
  logic            r_err;
  logic [7:0]      r_cnt;
  logic [AW-1:0]   r_addr;
  logic            r_wen;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wmask;

  logic            w_grant_ifu;
  logic            w_grant_lsu;
  logic            w_idle;
  logic            w_in_wait;
  logic            w_rsp_hit;
  logic            w_timeout;
  logic            w_done;
  logic            w_spurious;
  logic [DW-1:0]   w_rsp_data;

  // Round-robin: on a tie the master that did not win last time is granted.
  assign w_grant_ifu = ifu_req_valid && (!lsu_req_valid || r_last_lsu);
  assign w_grant_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);

  // Ready is additionally gated by rst so it drops the instant reset asserts,
  // even while a master keeps its valid high.
  assign w_idle        = (r_state == c_idle) && rst;
  assign ifu_req_ready = w_idle && w_grant_ifu;
  assign lsu_req_ready = w_idle && w_grant_lsu;

  // A real response always beats a timeout landing in the same cycle.
  assign w_in_wait  = (r_state == c_wait);
  assign w_rsp_hit  = w_in_wait && mem_rsp_valid;
  assign w_timeout  = w_in_wait && !mem_rsp_valid && (r_cnt == c_timeout);
  assign w_done     = w_rsp_hit || w_timeout;
  assign w_spurious = mem_rsp_valid && !w_in_wait;

  // Stores and aborted transactions return zero data.
  assign w_rsp_data = (w_rsp_hit && !r_wen) ? mem_rsp_data : '0;

  assign ifu_rsp_valid = w_done && !r_owner_lsu;
  assign lsu_rsp_valid = w_done && r_owner_lsu;
  assign ifu_rsp_data  = ifu_rsp_valid ? w_rsp_data : '0;
  assign lsu_rsp_data  = lsu_rsp_valid ? w_rsp_data : '0;

  assign mem_req_valid = (r_state == c_req);
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;

  assign err = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_idle;
      r_owner_lsu <= 1'b0;
      r_last_lsu  <= 1'b1;   // first tie after reset goes to the IFU
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else begin
      if (w_spurious || w_timeout) begin
        r_err <= 1'b1;
      end

      case (r_state)
        c_idle: begin
          if (w_grant_ifu || w_grant_lsu) begin
            r_state     <= c_req;
            r_owner_lsu <= w_grant_lsu;
            r_last_lsu  <= w_grant_lsu;
            r_addr      <= w_grant_lsu ? lsu_addr : ifu_addr;
            // Fetches are always plain reads with no write payload.
            r_wen       <= w_grant_lsu && lsu_wen;
            r_wdata     <= w_grant_lsu ? lsu_wdata : '0;
            r_wmask     <= w_grant_lsu ? lsu_wmask : '0;
          end
        end
        c_req: begin
          if (mem_req_ready) begin
            r_state <= c_wait;
            r_cnt   <= '0;
          end
        end
        c_wait: begin
          if (w_done) begin
            r_state <= c_idle;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_mem_arbiter
//  Purpose  : Directed self-checking bench for ysyx_mem_arbiter. Expected
//             responses are queued when the memory side is driven and popped
//             by a monitor when a master response strobe appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [AW-1:0]   ifu_addr;
  logic            ifu_rsp_valid;
  logic [DW-1:0]   ifu_rsp_data;
  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic [AW-1:0]   lsu_addr;
  logic            lsu_wen;
  logic [DW-1:0]   lsu_wdata;
  logic [DW/8-1:0] lsu_wmask;
  logic            lsu_rsp_valid;
  logic [DW-1:0]   lsu_rsp_data;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_wen;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic            err;

  ysyx_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_data  (lsu_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        lsu;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  logic model_last_lsu;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic lsu, input logic [31:0] data);
    rsp_t e;
    e.lsu  = lsu;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Any response strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (ifu_rsp_valid || lsu_rsp_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_owner", {ifu_rsp_valid, lsu_rsp_valid}, mon_e.lsu ? 2'b01 : 2'b10);
        check("rsp_data", mon_e.lsu ? lsu_rsp_data : ifu_rsp_data, mon_e.data);
      end
    end
  end

  // Single-master transaction: handshake, `stall` cycles of mem_req_ready=0
  // in REQ, then acceptance and a response on the first WAIT cycle.
  task automatic do_txn(input logic lsu, input logic [31:0] addr, input logic wen,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input logic [31:0] rdata, input int stall);
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen;
      lsu_wdata = wdata; lsu_wmask = wmask;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = addr;
    end
    mid();
    check("req_ready", {ifu_req_ready, lsu_req_ready}, lsu ? 2'b01 : 2'b10);
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    model_last_lsu = lsu;
    for (int s = 0; s <= stall; s++) begin
      mem_req_ready = (s == stall);
      mid();
      check("mem_req_valid", mem_req_valid, 1'b1);
      check("mem_addr", mem_addr, addr);
      check("mem_wen", mem_wen, lsu ? wen : 1'b0);
      check("mem_wdata", mem_wdata, lsu ? wdata : 32'h0);
      check("mem_wmask", mem_wmask, lsu ? wmask : 4'h0);
      check("req_ready_busy", {ifu_req_ready, lsu_req_ready}, 2'b00);
      tick();
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rdata;
    push_exp(lsu, (lsu && wen) ? 32'h0 : rdata);
    mid();
    check("mem_req_valid_wait", mem_req_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    check("rsp_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000;
    lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    model_last_lsu = 1'b1;

    // ---- reset values, asserted asynchronously before any clock edge ----
    #1 rst = 1'b0;
    #1;
    check("rst_ifu_ready", ifu_req_ready, 1'b0);
    check("rst_lsu_ready", lsu_req_ready, 1'b0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_mem_fields", {mem_addr, mem_wen, mem_wmask}, 37'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rsp", {ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_data, lsu_rsp_data}, 66'h0);
    check("rst_err", err, 1'b0);
    tick();
    tick();
    rst = 1'b1;

    // ---- contention: both valid for 6 transactions, first tie -> IFU ----
    for (int i = 0; i < 6; i++) begin
      logic exp_lsu;
      exp_lsu = !model_last_lsu;
      mid();
      check("tie_grant", {ifu_req_ready, lsu_req_ready}, exp_lsu ? 2'b01 : 2'b10);
      tick();
      model_last_lsu = exp_lsu;
      mem_req_ready = 1'b1;
      mid();
      check("tie_mem_addr", mem_addr, exp_lsu ? 32'h8000_2000 : 32'h8000_0100);
      check("tie_busy", {ifu_req_ready, lsu_req_ready}, 2'b00);
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h0000_1000 + 32'(i);
      push_exp(exp_lsu, 32'h0000_1000 + 32'(i));
      mid();
      tick();
      mem_rsp_valid = 1'b0;
      check("tie_rsp_pending", exp_q.size(), 0);
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;

    // ---- single fetch, store with 3 stall cycles, load ----
    do_txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 0);
    do_txn(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h5555_AAAA, 3);
    do_txn(1'b1, 32'h8000_1004, 1'b0, 32'h1111_2222, 4'h3, 32'hCAFE_F00D, 1);
    mid();
    check("err_clean", err, 1'b0);
    tick();

    // ---- timeout: abort exactly 4 cycles after WAIT entry ----
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0200;
    mid();
    check("to_ready", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    model_last_lsu = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_data = 32'hFFFF_FFFF;
    for (int w = 0; w < 4; w++) begin
      mid();
      check("to_no_rsp_early", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
      check("to_err_early", err, 1'b0);
      tick();
    end
    push_exp(1'b0, 32'h0);
    mid();
    tick();
    check("to_rsp_pending", exp_q.size(), 0);
    mid();
    check("to_err_set", err, 1'b1);
    tick();
    do_txn(1'b1, 32'h8000_1008, 1'b0, 32'h0, 4'h0, 32'h0BAD_CAFE, 0);
    mid();
    check("to_err_sticky", err, 1'b1);
    tick();

    // ---- reset in the middle of WAIT; memory answers during reset ----
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0;
    tick();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h1234_5678;
    #1;
    check("rstw_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    check("rstw_rsp_data", lsu_rsp_data, 32'h0);
    check("rstw_err", err, 1'b0);
    check("rstw_mem", {mem_req_valid, mem_addr}, 33'h0);
    tick();
    mem_rsp_valid = 1'b0;
    tick();
    rst = 1'b1;
    model_last_lsu = 1'b1;
    mid();
    check("rstw_err_after", err, 1'b0);
    tick();
    do_txn(1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h0000_0513, 0);

    // ---- spurious response in IDLE ----
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h7777_7777;
    mid();
    check("sp_no_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    tick();
    mem_rsp_valid = 1'b0;
    mid();
    check("sp_err", err, 1'b1);
    tick();
    do_txn(1'b1, 32'h8000_100C, 1'b1, 32'h0102_0304, 4'h5, 32'h9999_9999, 0);

    tick();
    check("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
